// File: rtl/skolem_chk_pkg.sv
// Shared definitions for the bvsle/bvshl Skolem checkers: state encoding,
// default widths and a reference form of the predicate at the default width.
package skolem_chk_pkg;

  localparam int W_DEF     = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // P(x) = $signed(x << s) <= $signed(t); shifts of W or more give 0.
  function automatic logic shl_sle(input logic [W_DEF-1:0] x,
                                   input logic [W_DEF-1:0] s,
                                   input logic [W_DEF-1:0] t);
    logic [W_DEF-1:0] sh;
    sh = ({1'b0, s} >= (W_DEF+1)'(W_DEF)) ? '0 : (x << s);
    return $signed(sh) <= $signed(t);
  endfunction

endpackage

// File: rtl/shl_sle_pred.sv
// Combinational predicate p = $signed(x << s) <= $signed(t) on W bits,
// with the shift truncated to W bits and any s >= W producing 0.
module shl_sle_pred #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         p
);

  logic [W-1:0] shifted;

  always_comb begin
    shifted = '0;
    if ({1'b0, s} < (W+1)'(W)) shifted = x << s;
    p = $signed(shifted) <= $signed(t);
  end

endmodule

// File: rtl/skolem_check_bvsle_bvshl.sv
// Sequential checker for the bvsle/bvshl Skolem netlist: sweeps every x to decide
// whether a witness exists, grades the candidate and counts failing results.
module skolem_check_bvsle_bvshl
  import skolem_chk_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     s,
  input  logic [W-1:0]     t,
  input  logic [W-1:0]     x_cand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             exists,
  output logic             cand_ok,
  output logic             pass,
  output logic [W-1:0]     witness,
  output logic [CNT_W-1:0] fail_count,
  output state_e           state_dbg
);

  // Handshakes: a tuple transfers on a rising edge with in_valid && in_ready, a
  // result transfers on a rising edge with out_valid && out_ready; the producer
  // holds its data stable while valid is high and ready is low.

  state_e             state_q, state_d;
  logic [W-1:0]       s_q, s_d, t_q, t_d, idx_q, idx_d, witness_q, witness_d;
  logic               exists_q, exists_d, cand_ok_q, cand_ok_d, pass_q, pass_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic               p_cand, p_idx;

  shl_sle_pred #(.W(W)) u_pred_cand (.x(x_cand), .s(s),   .t(t),   .p(p_cand));
  shl_sle_pred #(.W(W)) u_pred_idx  (.x(idx_q),  .s(s_q), .t(t_q), .p(p_idx));

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    t_d       = t_q;
    idx_d     = idx_q;
    witness_d = witness_q;
    exists_d  = exists_q;
    cand_ok_d = cand_ok_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d       = s;
          t_d       = t;
          cand_ok_d = p_cand;
          exists_d  = 1'b0;
          witness_d = '0;
          pass_d    = 1'b0;
          idx_d     = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        // First hit wins, so the witness is the smallest satisfying x.
        if (p_idx && !exists_q) begin
          exists_d  = 1'b1;
          witness_d = idx_q;
        end
        if (idx_q == '1) begin
          pass_d  = !(exists_q || p_idx) || cand_ok_q;
          state_d = DONE;
        end else begin
          idx_d = idx_q + W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          if (!pass_q && !(&fail_q)) fail_d = fail_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      t_q       <= '0;
      idx_q     <= '0;
      witness_q <= '0;
      exists_q  <= 1'b0;
      cand_ok_q <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      t_q       <= t_d;
      idx_q     <= idx_d;
      witness_q <= witness_d;
      exists_q  <= exists_d;
      cand_ok_q <= cand_ok_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign exists     = exists_q;
  assign cand_ok    = cand_ok_q;
  assign pass       = pass_q;
  assign witness    = witness_q;
  assign fail_count = fail_q;
  assign state_dbg  = state_q;

endmodule
